// File: rtl/pixel_ctrl_pkg.sv
// Shared types and constants for the pixel array controller.
package pixel_ctrl_pkg;

  localparam int unsigned PIXEL_BITS    = 8;
  localparam int unsigned CONVERT_STEPS = 256;
  localparam int unsigned ROW_IDX_W     = 4;
  localparam int unsigned TIMER_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_SELECT,
    ST_OUTPUT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/phase_timer.sv
// Phase-duration down-counter: load N, count down while enabled, expired when it reaches zero.
module phase_timer
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load wins, otherwise decrement and stick at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register; expired tracks count == 0 without a combinational tap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      expired <= 1'b1;
    end else begin
      count_q <= count_d;
      expired <= (count_d == '0);
    end
  end

endmodule

// File: rtl/pixel_array_controller.sv
// Frame sequencer for a pixel array: erase, expose, ramp conversion, then row-by-row readout.
module pixel_array_controller
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned ROWS          = 2,
  parameter int unsigned COLS          = 2,
  parameter int unsigned ERASE_CYCLES  = 4,
  parameter int unsigned EXPOSE_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       erase,
  output logic                       expose,
  output logic                       ramp,
  output logic [PIXEL_BITS-1:0]      counter,
  output logic [ROWS-1:0]            read_row,
  input  logic [COLS*PIXEL_BITS-1:0] pix_data,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [ROW_IDX_W-1:0]       row_index,
  output logic [COLS*PIXEL_BITS-1:0] row_data
);

  localparam int unsigned DATA_W   = COLS * PIXEL_BITS;
  localparam int unsigned CONV_LEN = 2 * CONVERT_STEPS;

  localparam logic [TIMER_W-1:0]   ERASE_LOAD  = TIMER_W'(ERASE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]   EXPOSE_LOAD = TIMER_W'(EXPOSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]   CONV_LOAD   = TIMER_W'(CONV_LEN - 1);
  localparam logic [ROW_IDX_W-1:0] LAST_ROW    = ROW_IDX_W'(ROWS - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [ROW_IDX_W-1:0]   row_q;
  logic [ROW_IDX_W-1:0]   row_d;

  logic                   timer_load;
  logic                   timer_enable;
  logic [TIMER_W-1:0]     timer_value;
  logic                   timer_expired;

  logic                   busy_d;
  logic                   frame_done_d;
  logic                   erase_d;
  logic                   expose_d;
  logic                   ramp_d;
  logic [PIXEL_BITS-1:0]  counter_d;
  logic [ROWS-1:0]        read_row_d;
  logic                   row_valid_d;
  logic [ROW_IDX_W-1:0]   row_index_d;
  logic [DATA_W-1:0]      row_data_d;

  // One timer sequences ERASE, EXPOSE and CONVERT durations.
  phase_timer #(
    .WIDTH (TIMER_W)
  ) u_phase_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_value),
    .enable     (timer_enable),
    .expired    (timer_expired)
  );

  // Next state, row pointer, timer control and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    timer_load   = 1'b0;
    timer_enable = 1'b0;
    timer_value  = '0;
    counter_d    = '0;
    ramp_d       = 1'b0;
    row_index_d  = row_index;
    row_data_d   = row_data;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_ERASE;
          timer_load  = 1'b1;
          timer_value = ERASE_LOAD;
        end
      end
      ST_ERASE: begin
        if (timer_expired) begin
          state_d     = ST_EXPOSE;
          timer_load  = 1'b1;
          timer_value = EXPOSE_LOAD;
        end else begin
          timer_enable = 1'b1;
        end
      end
      ST_EXPOSE: begin
        if (timer_expired) begin
          state_d     = ST_CONVERT;
          timer_load  = 1'b1;
          timer_value = CONV_LOAD;
        end else begin
          timer_enable = 1'b1;
        end
      end
      ST_CONVERT: begin
        // Each step is a ramp-low cycle followed by a ramp-high cycle at the same code.
        if (timer_expired) begin
          state_d = ST_SELECT;
          row_d   = '0;
        end else begin
          timer_enable = 1'b1;
          if (ramp) begin
            counter_d = counter + PIXEL_BITS'(1);
            ramp_d    = 1'b0;
          end else begin
            counter_d = counter;
            ramp_d    = 1'b1;
          end
        end
      end
      ST_SELECT: begin
        state_d     = ST_OUTPUT;
        row_index_d = row_q;
        row_data_d  = pix_data;
      end
      ST_OUTPUT: begin
        if (row_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SELECT;
            row_d   = row_q + ROW_IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        row_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        row_d   = '0;
      end
    endcase

    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
    erase_d      = (state_d == ST_ERASE);
    expose_d     = (state_d == ST_EXPOSE);
    row_valid_d  = (state_d == ST_OUTPUT);
    read_row_d   = ((state_d == ST_SELECT) || (state_d == ST_OUTPUT)) ? (ROWS'(1) << row_d) : '0;
  end

  // State, row pointer and all outputs registered together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      ramp       <= 1'b0;
      counter    <= '0;
      read_row   <= '0;
      row_valid  <= 1'b0;
      row_index  <= '0;
      row_data   <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      erase      <= erase_d;
      expose     <= expose_d;
      ramp       <= ramp_d;
      counter    <= counter_d;
      read_row   <= read_row_d;
      row_valid  <= row_valid_d;
      row_index  <= row_index_d;
      row_data   <= row_data_d;
    end
  end

endmodule

// File: tb/tb_pixel_array_controller.sv
// Self-checking bench for pixel_array_controller with a phase/time-based reference model.
module tb_pixel_array_controller;

  localparam int ROWS  = 2;
  localparam int COLS  = 2;
  localparam int EC    = 4;
  localparam int XC    = 255;
  localparam int STEPS = 256;
  localparam int CONV_START = EC + XC;
  localparam int PRE        = EC + XC + 2 * STEPS;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              row_ready = 1'b0;
  logic              busy, frame_done, erase, expose, ramp, row_valid;
  logic [7:0]        counter;
  logic [ROWS-1:0]   read_row;
  logic [3:0]        row_index;
  logic [COLS*8-1:0] row_data;
  logic [COLS*8-1:0] pix_data;
  logic [7:0]        lat [ROWS][COLS];
  logic [35:0]       dut_vec;

  int checks = 0;
  int failures = 0;
  int erase_cnt = 0, expose_cnt = 0, ramp_cnt = 0, fd_cnt = 0, max_cnt = 0;
  logic [19:0] acc_q[$];

  pixel_array_controller #(
    .ROWS (ROWS), .COLS (COLS), .ERASE_CYCLES (EC), .EXPOSE_CYCLES (XC)
  ) dut (
    .clk (clk), .reset_n (reset_n), .start (start), .busy (busy),
    .frame_done (frame_done), .erase (erase), .expose (expose), .ramp (ramp),
    .counter (counter), .read_row (read_row), .pix_data (pix_data),
    .row_valid (row_valid), .row_ready (row_ready), .row_index (row_index),
    .row_data (row_data)
  );

  always #5 clk = ~clk;

  // Pixel array: the selected row drives its latched codes onto the shared bus.
  assign pix_data = read_row[0] ? {lat[0][1], lat[0][0]} :
                    read_row[1] ? {lat[1][1], lat[1][0]} : '0;

  assign dut_vec = {busy, frame_done, erase, expose, ramp, counter, read_row,
                    row_valid, row_index, row_data};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame time t since start, then a row walk gated by row_ready.
  bit          m_active = 0, m_rowph = 0, m_out = 0, m_done = 0;
  int          m_t = 0, m_row = 0;
  logic [15:0] m_cap_data = '0;
  logic [3:0]  m_cap_idx = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 0; m_rowph = 0; m_out = 0; m_done = 0;
      m_t = 0; m_row = 0; m_cap_data = '0; m_cap_idx = '0;
    end else begin
      if (row_valid && row_ready) acc_q.push_back({row_index, row_data});
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_t = 0; m_rowph = 0; m_done = 0;
        end
      end else if (m_done) begin
        m_active = 0; m_done = 0;
      end else if (!m_rowph) begin
        m_t++;
        if (m_t == PRE) begin
          m_rowph = 1; m_row = 0; m_out = 0;
        end
      end else if (!m_out) begin
        m_cap_data = {lat[m_row][1], lat[m_row][0]};
        m_cap_idx  = 4'(m_row);
        m_out      = 1;
      end else if (row_ready) begin
        if (m_row == ROWS - 1) begin
          m_done = 1; m_rowph = 0; m_out = 0;
        end else begin
          m_row++; m_out = 0;
        end
      end
    end
  end

  function automatic logic [35:0] model_out();
    logic       b, fd, er, ex, rp, rv;
    logic [7:0] cnt;
    logic [1:0] rr;
    int         c;
    b = 0; fd = 0; er = 0; ex = 0; rp = 0; rv = 0; cnt = '0; rr = '0;
    if (m_active) begin
      b = 1;
      if (m_done) fd = 1;
      else if (m_rowph) begin
        rr = 2'(1 << m_row);
        rv = m_out;
      end else if (m_t < EC) er = 1;
      else if (m_t < CONV_START) ex = 1;
      else begin
        c   = m_t - CONV_START;
        cnt = 8'(c / 2);
        rp  = ((c % 2) == 1);
      end
    end
    return {b, fd, er, ex, rp, cnt, rr, rv, m_cap_idx, m_cap_data};
  endfunction

  // Per-cycle comparison against the model plus strobe exclusivity and one-hot row select.
  always @(negedge clk) begin
    chk("outputs", 64'(dut_vec), 64'(model_out()));
    chk("exclusive", 64'($countones({erase, expose, ramp, |read_row}) <= 1), 64'(1));
    chk("onehot", 64'($countones(read_row) <= 1), 64'(1));
    if (erase) erase_cnt++;
    if (expose) expose_cnt++;
    if (ramp) ramp_cnt++;
    if (frame_done) fd_cnt++;
    if (int'(counter) > max_cnt) max_cnt = int'(counter);
  end

  task automatic clear_counts();
    erase_cnt = 0; expose_cnt = 0; ramp_cnt = 0; fd_cnt = 0; max_cnt = 0;
    acc_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_for(input int which, input int budget, input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = frame_done;
        1: hit = row_valid;
        2: hit = expose;
        3: hit = (counter == 8'd100);
        default: hit = !busy;
      endcase
    end
    chk({"timeout_", name}, 64'(hit), 64'(1));
  endtask

  task automatic check_frame(input string tag, input logic [15:0] r0, input logic [15:0] r1);
    chk({tag, "_busy_low"}, 64'(busy), 64'(0));
    chk({tag, "_erase_cycles"}, 64'(erase_cnt), 64'(4));
    chk({tag, "_expose_cycles"}, 64'(expose_cnt), 64'(255));
    chk({tag, "_ramp_cycles"}, 64'(ramp_cnt), 64'(256));
    chk({tag, "_counter_max"}, 64'(max_cnt), 64'(255));
    chk({tag, "_frame_done"}, 64'(fd_cnt), 64'(1));
    chk({tag, "_rows"}, 64'(acc_q.size()), 64'(2));
    chk({tag, "_row0"}, 64'(acc_q.size() > 0 ? acc_q[0] : 20'hFFFFF), 64'({4'd0, r0}));
    chk({tag, "_row1"}, 64'(acc_q.size() > 1 ? acc_q[1] : 20'hFFFFF), 64'({4'd1, r1}));
  endtask

  initial begin
    lat[0][0] = 8'd2; lat[0][1] = 8'd4; lat[1][0] = 8'd4; lat[1][1] = 8'd8;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(dut_vec), 64'(0));
    reset_n = 1'b1;

    // Full frame, downstream always ready.
    row_ready = 1'b1;
    clear_counts();
    pulse_start();
    wait_for(0, 1000, "frameA");
    @(negedge clk);
    check_frame("A", 16'h0402, 16'h0804);

    // Backpressure: hold ready low for 10 OUTPUT cycles.
    lat[0][0] = 8'h5A; lat[0][1] = 8'hA5; lat[1][0] = 8'h3C; lat[1][1] = 8'hC3;
    row_ready = 1'b0;
    clear_counts();
    pulse_start();
    wait_for(1, 1000, "validB");
    for (int i = 0; i < 10; i++) begin
      chk("B_stall_hold", 64'({row_valid, read_row, row_index, row_data}),
          64'({1'b1, 2'b01, 4'd0, 16'hA55A}));
      @(negedge clk);
    end
    chk("B_no_accept_stalled", 64'(acc_q.size()), 64'(0));
    row_ready = 1'b1;
    wait_for(0, 100, "frameB");
    @(negedge clk);
    check_frame("B", 16'hA55A, 16'hC33C);

    // Starts during EXPOSE and during DONE must be ignored.
    clear_counts();
    pulse_start();
    wait_for(2, 100, "exposeC");
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_for(0, 1000, "frameC");
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_frame("C", 16'hA55A, 16'hC33C);
    repeat (20) @(negedge clk);
    chk("C_still_idle", 64'(busy), 64'(0));
    chk("C_no_second_frame", 64'(erase_cnt), 64'(4));

    // Reset in the middle of CONVERT, then a fresh frame.
    clear_counts();
    pulse_start();
    wait_for(3, 2000, "convD");
    #2 reset_n = 1'b0;
    #1 chk("D_async_reset", 64'(dut_vec), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("D_no_frame_done", 64'(fd_cnt), 64'(0));
    chk("D_idle_after_reset", 64'(busy), 64'(0));
    clear_counts();
    pulse_start();
    wait_for(0, 1000, "frameD");
    @(negedge clk);
    check_frame("D", 16'hA55A, 16'hC33C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
